// File: rtl/vlc_link_scheduler.sv
// rtl/vlc_link_scheduler.sv - half-duplex medium-access scheduler for the VLC link
//
// Arbitrates the shared optical channel between the TX path (DAC) and the RX
// path (ADC). TX is deferred while a frame is being received, then retried
// after a random backoff. The receiver is blanked during TX and for a guard
// interval afterwards.
//
// Ports:
//   clk          system clock (20 MHz)
//   reset        synchronous, active-low reset
//   i_tx_req     level, TX path holds a complete frame
//   i_tx_done    pulse, TX path finished the frame
//   i_rx_busy    level, RX path is receiving a frame
//   o_tx_grant   level, TX path may drive the DAC
//   o_tx_abort   pulse, grant revoked by timeout
//   o_rx_en      level, RX path may accept samples
//   o_state      current FSM state (debug/LEDs)
//   o_tx_frames  completed TX frames, wraps
//   o_rx_frames  completed RX frames, wraps
//   o_deferrals  TX requests deferred by RX activity, saturates at 255
module vlc_link_scheduler #(
  parameter int GUARD_CYCLES = 200,
  parameter int BACKOFF_UNIT = 64,
  parameter int TX_TIMEOUT   = 1048576,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tx_req,
  input  logic             i_tx_done,
  input  logic             i_rx_busy,
  output logic             o_tx_grant,
  output logic             o_tx_abort,
  output logic             o_rx_en,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_tx_frames,
  output logic [CNT_W-1:0] o_rx_frames,
  output logic [7:0]       o_deferrals
);

  // One countdown serves both backoff and guard, so size it for the longer.
  localparam int BO_MAX = 16 * BACKOFF_UNIT - 1;
  localparam int CD_MAX = (GUARD_CYCLES - 1 > BO_MAX) ? GUARD_CYCLES - 1 : BO_MAX;
  localparam int CD_W   = $clog2(CD_MAX + 1);
  localparam int TC_W   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX      = 3'd1,
    S_BACKOFF = 3'd2,
    S_TX      = 3'd3,
    S_GUARD   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        lfsr;
  logic              lfsr_fb;
  logic              rx_busy_q;
  logic              rx_fall;
  logic [CD_W-1:0]   countdown;
  logic [CD_W-1:0]   backoff_load;
  logic [TC_W-1:0]   tx_cycles;
  logic              rx_end;
  logic              defer;
  logic              frame_done;
  logic              tx_timeout;

  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign rx_fall      = rx_busy_q & ~i_rx_busy;
  assign backoff_load = CD_W'((int'(lfsr[3:0]) + 1) * BACKOFF_UNIT - 1);
  assign o_state      = state;

  always_comb begin
    state_nxt  = state;
    rx_end     = 1'b0;
    defer      = 1'b0;
    frame_done = 1'b0;
    tx_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        // RX has priority over a same-cycle TX request.
        if (i_rx_busy)     state_nxt = S_RX;
        else if (i_tx_req) state_nxt = S_TX;
      end
      S_RX: begin
        if (rx_fall) begin
          rx_end = 1'b1;
          if (i_tx_req) begin
            defer     = 1'b1;
            state_nxt = S_BACKOFF;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_BACKOFF: begin
        if (i_rx_busy)            state_nxt = S_RX;
        else if (countdown == '0) state_nxt = i_tx_req ? S_TX : S_IDLE;
      end
      S_TX: begin
        // Done wins over a timeout landing on the same cycle.
        if (i_tx_done) begin
          frame_done = 1'b1;
          state_nxt  = S_GUARD;
        end else if (tx_cycles == TC_W'(TX_TIMEOUT - 1)) begin
          tx_timeout = 1'b1;
          state_nxt  = S_GUARD;
        end
      end
      S_GUARD: begin
        if (countdown == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      o_tx_grant  <= 1'b0;
      o_tx_abort  <= 1'b0;
      o_rx_en     <= 1'b1;
      o_tx_frames <= '0;
      o_rx_frames <= '0;
      o_deferrals <= '0;
      lfsr        <= 8'hA5;
      countdown   <= '0;
      tx_cycles   <= '0;
      rx_busy_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= {lfsr[6:0], lfsr_fb};
      rx_busy_q  <= i_rx_busy;
      o_tx_grant <= (state_nxt == S_TX);
      o_rx_en    <= !(state_nxt == S_TX || state_nxt == S_GUARD);
      o_tx_abort <= tx_timeout;

      // Counts cycles spent in TX; reads 0 on the first granted cycle.
      tx_cycles <= (state == S_TX) ? tx_cycles + 1'b1 : '0;

      if (defer)
        countdown <= backoff_load;
      else if (state == S_TX && state_nxt == S_GUARD)
        countdown <= CD_W'(GUARD_CYCLES - 1);
      else if (state_nxt == S_BACKOFF || state_nxt == S_GUARD)
        countdown <= countdown - 1'b1;
      else
        countdown <= '0;

      if (frame_done) o_tx_frames <= o_tx_frames + 1'b1;
      if (rx_end)     o_rx_frames <= o_rx_frames + 1'b1;
      if (defer && o_deferrals != 8'hFF) o_deferrals <= o_deferrals + 1'b1;
    end
  end

endmodule

// File: tb/tb_vlc_link_scheduler.sv
// tb/tb_vlc_link_scheduler.sv - scoreboard bench for vlc_link_scheduler
module tb_vlc_link_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_req = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_busy = 1'b0;
  logic       tx_grant;
  logic       tx_abort;
  logic       rx_en;
  logic [2:0] state;
  logic [2:0] tx_frames;
  logic [2:0] rx_frames;
  logic [7:0] deferrals;

  vlc_link_scheduler #(
    .GUARD_CYCLES(200),
    .BACKOFF_UNIT(64),
    .TX_TIMEOUT  (1000),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_tx_req   (tx_req),
    .i_tx_done  (tx_done),
    .i_rx_busy  (rx_busy),
    .o_tx_grant (tx_grant),
    .o_tx_abort (tx_abort),
    .o_rx_en    (rx_en),
    .o_state    (state),
    .o_tx_frames(tx_frames),
    .o_rx_frames(rx_frames),
    .o_deferrals(deferrals)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output snapshot: {state, grant, rx_en, abort, txf, rxf, dfr}.
  typedef struct packed {
    int          c;
    logic [19:0] v;
  } ev_t;

  ev_t  q[$];
  int   total = 0;
  int   passed = 0;
  logic armed = 1'b0;
  logic probe = 1'b0;
  int   rst_rel = 0;

  logic [2:0] m_st = 3'd0;
  logic       m_g = 1'b0, m_en = 1'b1, m_ab = 1'b0;
  logic [2:0] m_txf = 3'd0, m_rxf = 3'd0;
  logic [7:0] m_dfr = 8'd0;

  task automatic push(input int at);
    ev_t e;
    e.c = at;
    e.v = {m_st, m_g, m_en, m_ab, m_txf, m_rxf, m_dfr};
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // Backoff LFSR value held just before posedge number 'at'.
  function automatic int backoff_len(input int at);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < at - 1 - rst_rel; i++)
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return (int'(l[3:0]) + 1) * 64;
  endfunction

  // Monitor: any output change (or a probe) pops one expected snapshot.
  initial begin
    logic [19:0] vec;
    logic [19:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #2;
      vec = {state, tx_grant, rx_en, tx_abort, tx_frames, rx_frames, deferrals};
      if (armed && (vec !== prev || probe)) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event: cyc=%0d out=%h, no event expected", cyc, vec);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.v !== vec)
            $display("FAIL event: got cyc=%0d out=%h, expected cyc=%0d out=%h", cyc, vec, e.c, e.v);
          else
            passed++;
        end
      end
      prev = vec;
    end
  end

  initial begin
    int c, g, n;
    ev_t e;

    // Reset held for three edges, outputs probed on the third.
    step();
    armed = 1'b1;
    step();
    push(cyc + 1);
    probe = 1'b1;
    step();
    probe = 1'b0;
    reset = 1'b1;
    rst_rel = cyc;
    tx_req = 1'b1;
    m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
    push(cyc + 1);
    g = cyc + 1;

    // Single frame, done 100 cycles after grant, then 200-cycle guard.
    wait_until(g + 99);
    tx_done = 1'b1;
    tx_req = 1'b0;
    m_st = 3'd4; m_g = 1'b0; m_txf = m_txf + 3'd1;
    push(g + 100);
    m_st = 3'd0; m_en = 1'b1;
    push(g + 300);
    step();
    tx_done = 1'b0;
    wait_until(g + 305);

    // Deferral: RX for 500 cycles, request arrives 50 cycles in.
    c = cyc;
    rx_busy = 1'b1;
    m_st = 3'd1;
    push(c + 1);
    repeat (50) step();
    tx_req = 1'b1;
    wait_until(c + 500);
    rx_busy = 1'b0;
    n = backoff_len(c + 501);
    m_st = 3'd2; m_rxf = m_rxf + 3'd1; m_dfr = m_dfr + 8'd1;
    push(c + 501);
    g = c + 501 + n;
    m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
    push(g);
    wait_until(g + 9);
    tx_done = 1'b1;
    tx_req = 1'b0;
    m_st = 3'd4; m_g = 1'b0; m_txf = m_txf + 3'd1;
    push(g + 10);
    m_st = 3'd0; m_en = 1'b1;
    push(g + 210);
    step();
    tx_done = 1'b0;
    wait_until(g + 215);

    // Simultaneous RX and TX request, then RX again mid-backoff, then timeout.
    c = cyc;
    rx_busy = 1'b1;
    tx_req = 1'b1;
    m_st = 3'd1;
    push(c + 1);
    wait_until(c + 20);
    rx_busy = 1'b0;
    m_st = 3'd2; m_rxf = m_rxf + 3'd1; m_dfr = m_dfr + 8'd1;
    push(c + 21);
    wait_until(c + 31);
    rx_busy = 1'b1;
    m_st = 3'd1;
    push(c + 32);
    wait_until(c + 61);
    rx_busy = 1'b0;
    n = backoff_len(c + 62);
    m_st = 3'd2; m_rxf = m_rxf + 3'd1; m_dfr = m_dfr + 8'd1;
    push(c + 62);
    g = c + 62 + n;
    m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
    push(g);
    wait_until(g);
    tx_req = 1'b0;
    m_st = 3'd4; m_g = 1'b0; m_ab = 1'b1;
    push(g + 1000);
    m_ab = 1'b0;
    push(g + 1001);
    m_st = 3'd0; m_en = 1'b1;
    push(g + 1200);
    wait_until(g + 1205);

    // Done on the exact timeout cycle counts as a frame, no abort.
    step();
    tx_req = 1'b1;
    m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
    g = cyc + 1;
    push(g);
    wait_until(g + 999);
    tx_done = 1'b1;
    tx_req = 1'b0;
    m_st = 3'd4; m_g = 1'b0; m_txf = m_txf + 3'd1;
    push(g + 1000);
    m_st = 3'd0; m_en = 1'b1;
    push(g + 1200);
    step();
    tx_done = 1'b0;
    wait_until(g + 1205);

    // Reset mid-grant drops the grant without an abort pulse.
    step();
    tx_req = 1'b1;
    m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
    g = cyc + 1;
    push(g);
    wait_until(g + 50);
    reset = 1'b0;
    tx_req = 1'b0;
    m_st = 3'd0; m_g = 1'b0; m_en = 1'b1; m_ab = 1'b0;
    m_txf = 3'd0; m_rxf = 3'd0; m_dfr = 8'd0;
    push(g + 51);
    step();
    step();
    reset = 1'b1;
    rst_rel = cyc;

    // Eight short frames wrap the 3-bit TX counter.
    for (int i = 0; i < 8; i++) begin
      step();
      tx_req = 1'b1;
      m_st = 3'd3; m_g = 1'b1; m_en = 1'b0;
      g = cyc + 1;
      push(g);
      step();
      tx_done = 1'b1;
      tx_req = 1'b0;
      m_st = 3'd4; m_g = 1'b0; m_txf = m_txf + 3'd1;
      push(g + 1);
      m_st = 3'd0; m_en = 1'b1;
      push(g + 201);
      step();
      tx_done = 1'b0;
      wait_until(g + 203);
    end

    // Stray done in IDLE must not change anything.
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (3) step();

    // Repeated RX bursts interrupting backoff saturate the deferral count.
    rx_busy = 1'b1;
    tx_req = 1'b1;
    m_st = 3'd1;
    push(cyc + 1);
    for (int i = 0; i < 260; i++) begin
      step();
      rx_busy = 1'b0;
      m_st = 3'd2; m_rxf = m_rxf + 3'd1;
      if (m_dfr != 8'hFF) m_dfr = m_dfr + 8'd1;
      push(cyc + 1);
      step();
      rx_busy = 1'b1;
      m_st = 3'd1;
      push(cyc + 1);
    end
    step();
    rx_busy = 1'b0;
    tx_req = 1'b0;
    m_st = 3'd0; m_rxf = m_rxf + 3'd1;
    push(cyc + 1);
    repeat (10) step();

    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL missing_event: got none by cyc=%0d, expected cyc=%0d out=%h", cyc, e.c, e.v);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vlc_link_scheduler.md
Name: vlc_link_scheduler

Overview:
Half-duplex medium-access controller for the VLC link. It arbitrates the shared optical channel between the SLIP TX path (DAC side) and the RX path (ADC side). It grants transmit windows, defers transmission while a frame is being received, and applies randomized backoff after receive activity. It blanks the receiver during transmission plus a turnaround guard interval, and keeps link statistics. It sits in the top level between the tx/rx loop instances and the shared 20 MHz clock/reset.

Parameters:
GUARD_CYCLES, 200, receiver blanking cycles after TX end (10 us at 20 MHz); must be >= 1
BACKOFF_UNIT, 64, cycles per backoff slot; must be >= 1
TX_TIMEOUT, 1048576, maximum cycles a grant may be held before forced abort
CNT_W, 16, width of frame counters

Ports:
clk  in  1  system clock (20 MHz PLL output)
reset  in  1  synchronous, active-low reset
i_tx_req  in  1  level; TX path holds a complete frame ready
i_tx_done  in  1  one-cycle pulse; TX path finished sending frame
i_rx_busy  in  1  level; RX path detected carrier/SFD, high until frame end
o_tx_grant  out  1  level; TX path may drive DAC
o_tx_abort  out  1  one-cycle pulse; grant revoked by timeout
o_rx_en  out  1  level; RX path may accept samples
o_state  out  3  current FSM state encoding (debug/LEDs)
o_tx_frames  out  CNT_W  completed TX frames, wraps
o_rx_frames  out  CNT_W  completed RX frames, wraps
o_deferrals  out  8  TX requests deferred by RX activity, saturates at 255

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE (3'd0), o_tx_grant=0, o_tx_abort=0, o_rx_en=1, all counters=0, LFSR=8'hA5, countdown=0. Reset mid-operation aborts any grant immediately and does not pulse o_tx_abort.
- All outputs are registered. o_rx_en=1 in IDLE, RX_ACTIVE and BACKOFF; 0 in TX_ACTIVE and GUARD. o_tx_grant=1 only in TX_ACTIVE.
- Backoff randomness: 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle out of reset.
- i_rx_busy falling edge: detected against a registered copy of i_rx_busy.
- States and transitions:
  - IDLE (0): if i_rx_busy, go to RX_ACTIVE. RX wins a same-cycle i_tx_req. Otherwise, if i_tx_req, go to TX_ACTIVE; o_tx_grant rises 1 cycle after the request is sampled.
  - RX_ACTIVE (1): if i_tx_req is high on any cycle here, set a deferred flag. On i_rx_busy falling edge, increment o_rx_frames.
    - If i_tx_req is high at that point, go to BACKOFF with countdown=(LFSR[3:0]+1)*BACKOFF_UNIT-1 and increment o_deferrals once (saturating).
    - Otherwise go to IDLE.
  - BACKOFF (2): decrement countdown each cycle.
    - i_rx_busy high: go to RX_ACTIVE and discard countdown. A further deferral counts again.
    - countdown==0 and i_tx_req high: go to TX_ACTIVE.
    - countdown==0 and i_tx_req low: go to IDLE.
  - TX_ACTIVE (3): i_rx_busy is ignored (receiver blanked). A cycle counter starts at 0 on entry.
    - i_tx_done: increment o_tx_frames and go to GUARD.
    - Counter reaches TX_TIMEOUT-1 without i_tx_done: pulse o_tx_abort for 1 cycle, go to GUARD, o_tx_frames unchanged.
    - i_tx_done in the same cycle as timeout: treated as done, no abort.
  - GUARD (4): load countdown=GUARD_CYCLES-1 on entry and decrement to 0, then go to IDLE. o_rx_en stays 0 for exactly GUARD_CYCLES cycles after leaving TX_ACTIVE. i_tx_req and i_rx_busy are ignored.
- Any i_tx_done outside TX_ACTIVE is ignored. States 5–7 are unreachable; if entered, go to IDLE next cycle.
- Counter wrap: o_tx_frames/o_rx_frames wrap from 2^CNT_W-1 to 0. o_deferrals holds at 255.
- Latency: IDLE request to grant is 1 cycle. TX end to RX re-enable is GUARD_CYCLES cycles.

Test Plan:
- Reset with reset=0 for 3 cycles, then release with i_tx_req=1 -> state=IDLE, o_rx_en=1 during reset; o_tx_grant=1 on 2nd cycle after release.
- Single frame: i_tx_req=1, i_tx_done pulse 100 cycles after grant -> o_tx_frames=1, o_rx_en=0 for exactly 200 cycles, then state=IDLE.
- Deferral: i_rx_busy high for 500 cycles, i_tx_req asserted at cycle 50 -> no grant during RX, o_rx_frames=1, o_deferrals=1, grant after (LFSR[3:0]+1)*64 cycles, where the LFSR value is checked by the reference model.
- RX during backoff: reassert i_rx_busy mid-backoff -> state=RX_ACTIVE, o_deferrals=2 after second RX end.
- Simultaneous i_rx_busy and i_tx_req in IDLE -> RX_ACTIVE, o_tx_grant stays 0.
- Timeout with TX_TIMEOUT=1000 and no i_tx_done -> o_tx_abort pulse 1 cycle at cycle 1000 of grant, o_tx_frames=0, GUARD entered. Reset asserted mid-grant -> o_tx_grant=0 next cycle, no abort pulse.
